// File: rtl/priority_encoder32.sv
// 32-input priority encoder (bit 0 wins) with combinational results and a
// registered copy of both, built as eight 4-bit group encoders plus an 8-way group selector.
module priority_encoder32 (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] inputSignals,
    output logic        anySignalActive,
    output logic [4:0]  activeSignalIndex,
    output logic        registeredAnySignalActive,
    output logic [4:0]  registeredActiveSignalIndex
);

    logic [7:0] groupAny;
    logic [1:0] localIndex [8];
    logic [2:0] groupSelect;

    // Each local index falls back to 0 when its group is idle, so an all-zero
    // input yields index 0 with no extra gating.
    always_comb begin
        for (int g = 0; g < 8; g++) begin
            groupAny[g] = |inputSignals[4*g +: 4];
            if (inputSignals[4*g])
                localIndex[g] = 2'd0;
            else if (inputSignals[4*g+1])
                localIndex[g] = 2'd1;
            else if (inputSignals[4*g+2])
                localIndex[g] = 2'd2;
            else if (inputSignals[4*g+3])
                localIndex[g] = 2'd3;
            else
                localIndex[g] = 2'd0;
        end
    end

    // Scanning from the top lets the lowest active group overwrite the others.
    always_comb begin
        groupSelect = 3'd0;
        for (int g = 7; g >= 0; g--) begin
            if (groupAny[g])
                groupSelect = 3'(g);
        end
    end

    assign anySignalActive   = |groupAny;
    assign activeSignalIndex = {groupSelect, localIndex[groupSelect]};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            registeredAnySignalActive   <= 1'b0;
            registeredActiveSignalIndex <= 5'd0;
        end else begin
            registeredAnySignalActive   <= anySignalActive;
            registeredActiveSignalIndex <= activeSignalIndex;
        end
    end

endmodule

// File: tb/tb_priority_encoder32.sv
// Directed bench for priority_encoder32: combinational priority results and
// the registered copy's reset and one-cycle behaviour.
module tb_priority_encoder32;

    logic        clk;
    logic        reset;
    logic [31:0] inputSignals;
    logic        anySignalActive;
    logic [4:0]  activeSignalIndex;
    logic        registeredAnySignalActive;
    logic [4:0]  registeredActiveSignalIndex;

    int checkCount = 0;
    int errorCount = 0;

    priority_encoder32 dut (
        .clk                         (clk),
        .reset                       (reset),
        .inputSignals                (inputSignals),
        .anySignalActive             (anySignalActive),
        .activeSignalIndex           (activeSignalIndex),
        .registeredAnySignalActive   (registeredAnySignalActive),
        .registeredActiveSignalIndex (registeredActiveSignalIndex)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [5:0] observed, input logic [5:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got any=%0b idx=%0d, expected any=%0b idx=%0d",
                     tag, observed[5], observed[4:0], expected[5], expected[4:0]);
        end
    endtask

    task automatic applyStimulus(input logic [31:0] value);
        inputSignals = value;
        #1;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    logic [31:0] walkBase;
    logic [31:0] walkVector;
    logic [31:0] lowMask;

    initial begin
        reset        = 1'b1;
        inputSignals = 32'h0;
        #1;
        checkOutput("resetRegistered", {registeredAnySignalActive, registeredActiveSignalIndex}, 6'd0);
        @(negedge clk);
        reset = 1'b0;

        applyStimulus(32'h0000_0000);
        checkOutput("allZero", {anySignalActive, activeSignalIndex}, {1'b0, 5'd0});
        applyStimulus(32'h0000_0001);
        checkOutput("bit0", {anySignalActive, activeSignalIndex}, {1'b1, 5'd0});
        applyStimulus(32'h0000_0002);
        checkOutput("bit1", {anySignalActive, activeSignalIndex}, {1'b1, 5'd1});
        applyStimulus(32'h8000_0000);
        checkOutput("bit31", {anySignalActive, activeSignalIndex}, {1'b1, 5'd31});
        applyStimulus(32'h0000_0003);
        checkOutput("twoLow", {anySignalActive, activeSignalIndex}, {1'b1, 5'd0});
        applyStimulus(32'h5938_C800);
        checkOutput("dense11", {anySignalActive, activeSignalIndex}, {1'b1, 5'd11});
        applyStimulus(32'h4000_0000);
        checkOutput("bit30", {anySignalActive, activeSignalIndex}, {1'b1, 5'd30});
        applyStimulus(32'h0010_0010);
        checkOutput("groupBoundary", {anySignalActive, activeSignalIndex}, {1'b1, 5'd4});

        walkBase = 32'h5938_C9CB;
        for (int k = 0; k < 32; k++) begin
            lowMask    = (32'd1 << k) - 32'd1;
            walkVector = (walkBase & ~lowMask) | (32'd1 << k);
            applyStimulus(walkVector);
            checkOutput($sformatf("walk%0d", k), {anySignalActive, activeSignalIndex}, {1'b1, 5'(k)});
        end

        applyStimulus(32'h0000_0000);
        checkOutput("backToZero", {anySignalActive, activeSignalIndex}, {1'b0, 5'd0});

        // Load a nonzero value into the registers, then reset between edges.
        @(negedge clk);
        applyStimulus(32'h0000_0100);
        @(posedge clk);
        #1;
        checkOutput("regLoad8", {registeredAnySignalActive, registeredActiveSignalIndex}, {1'b1, 5'd8});
        @(negedge clk);
        reset = 1'b1;
        #1;
        checkOutput("asyncReset", {registeredAnySignalActive, registeredActiveSignalIndex}, 6'd0);
        checkOutput("combDuringReset", {anySignalActive, activeSignalIndex}, {1'b1, 5'd8});
        @(posedge clk);
        #1;
        checkOutput("holdInReset", {registeredAnySignalActive, registeredActiveSignalIndex}, 6'd0);

        @(negedge clk);
        reset = 1'b0;
        applyStimulus(32'h0001_0000);
        checkOutput("afterRelease", {registeredAnySignalActive, registeredActiveSignalIndex}, 6'd0);
        @(posedge clk);
        #1;
        checkOutput("regLoad16", {registeredAnySignalActive, registeredActiveSignalIndex}, {1'b1, 5'd16});

        @(negedge clk);
        applyStimulus(32'h0000_0003);
        checkOutput("midCycleHold", {registeredAnySignalActive, registeredActiveSignalIndex}, {1'b1, 5'd16});
        @(posedge clk);
        #1;
        checkOutput("regLoad0", {registeredAnySignalActive, registeredActiveSignalIndex}, {1'b1, 5'd0});

        @(negedge clk);
        applyStimulus(32'h0000_0000);
        @(posedge clk);
        #1;
        checkOutput("regIdle", {registeredAnySignalActive, registeredActiveSignalIndex}, {1'b0, 5'd0});

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
